operand_fetch_sequencer: RTL
============================

Name: operand_fetch_sequencer

Overview:
- Sequences register-file reads and second-operand selection for each decoded SPARC instruction, then hands a complete operand bundle to the execute stage.
- Sits between decode and ALU/LSU. Drives the two read ports of the register file.
- Selects operand 2 from R[rs2], sign-extended simm13, SETHI imm22<<10, or CALL disp30<<2.
- Stores need more reads than the register file has ports. For those the block inserts a second read cycle, so throughput is 1 instruction per cycle except for multi-read stores.

Parameters:
DATA_W, 32, register/operand width (only 32 supported)
ZERO_G0, 1, when 1 any read of register address 0 yields 0 regardless of rf_data

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  decode presents an instruction
instr  in  32  instruction word
instr_ready  out  1  sequencer accepts instr this cycle
flush  in  1  synchronous pipeline flush
rf_addr_a  out  5  register file read port A address
rf_addr_b  out  5  register file read port B address
rf_data_a  in  32  port A data (combinational, same cycle)
rf_data_b  in  32  port B data (combinational, same cycle)
op_valid  out  1  operand bundle valid
op_ready  in  1  execute consumes the bundle
op_instr  out  32  instruction that owns the bundle
op_a  out  32  R[rs1]
op_b  out  32  second operand
op_st_lo  out  32  store data R[rd] (0 if not a store)
op_st_hi  out  32  R[rd|1] for STD (0 otherwise)

Behaviour:
- Reset (async): state=FETCH; op_valid=0; op_instr, op_a, op_b, op_st_lo, op_st_hi=0; held-instruction register=0.
- States are FETCH and EXTRA.
- instr_ready = (state==FETCH) && !flush && (!op_valid || op_ready).
- Accept occurs when instr_valid && instr_ready.
- Field decode: op=instr[31:30]; rd=[29:25]; op3=[24:19]; rs1=[18:14]; i=[13]; rs2=[4:0].
- Store = op==2'b11 && op3[5:4]==2'b00 && op3[2]==1. STD = store && op3==6'h07.
- Single-cycle class is every non-store, plus ST/STB/STH with i=1.
- Two-cycle class is STD (either i), plus ST/STB/STH with i=0.
- FETCH port addresses:
  - rf_addr_a = rs1.
  - rf_addr_b = rd for single-cycle stores, rs2 otherwise.
- Operand-2 mux, evaluated in FETCH:
  - op==00 -> {imm22,10'b0}.
  - op==01 -> {instr[29:0],2'b00}.
  - op==1x, i=1 -> sign-extend instr[12:0].
  - op==1x, i=0 -> port B data.
- Single-cycle accept: at the edge, load op_instr, op_a, op_b. Load op_st_lo = port B data for stores, else 0. Set op_st_hi=0 and op_valid=1. Latency is 1 cycle.
- Two-cycle accept:
  - At the accept edge, load op_a/op_b into internal holding and latch instr. op_valid is cleared if it was being consumed. Go to EXTRA.
  - In EXTRA, rf_addr_a=rd and rf_addr_b=rd|1 from the held instruction.
  - At the EXTRA edge, load the bundle. op_st_lo = port A data. op_st_hi = port B data if STD, else 0. Set op_valid=1 and return to FETCH. Latency is 2 cycles.
- Because accept requires the output to be free, op_valid is always 0 during EXTRA. No stall occurs in EXTRA.
- Output hold: while op_valid && !op_ready, every op_* output holds stable.
- If op_valid && op_ready and there is no new load, op_valid→0.
- When ZERO_G0=1, any operand read from address 0 is 0. rd|1 with rd=0 reads address 1 (normal).
- STD with odd rd: rd|1==rd, so both halves equal R[rd] (architecturally illegal; no trap here).
- flush (synchronous, priority over everything except reset): next edge op_valid=0, state=FETCH. Any EXTRA in progress is discarded. No accept that cycle.
- Simultaneous op_ready and accept: consumed bundle leaves, new single-cycle bundle appears next cycle, so back-to-back is allowed.
- Reset asserted mid-EXTRA returns immediately to FETCH with all outputs 0.
- In FETCH with no accept, rf_addr_* are driven from instr regardless of instr_valid.

Test Plan:
1. Immediate add. Stimulus: op=10, i=1, rs1=1, simm13=0x1FFF, R1=0x10. Required: op_valid 1 cycle after accept; op_a=0x10; op_b=0xFFFFFFFF; op_st_lo=0.
2. SETHI with operand-2 stream. Stimulus: SETHI imm22=0x3FFFFF. Required: op_b=0xFFFFFC00. Also issue a register-form add, rs2=3, R3=0x1234 → op_b=0x1234. Also stream 4 single-cycle instrs with op_ready=1 → 4 consecutive op_valid cycles with instr_ready held high.
3. STD, i=0. Stimulus: rs1=2, rs2=3, rd=4, with R2=0x100, R3=4, R4=0xAA, R5=0xBB. Required: cycle 0 addr 2/3; cycle 1 addr 4/5; instr_ready=0 during EXTRA; op_valid at cycle 2; op_st_lo=0xAA; op_st_hi=0xBB.
4. Backpressure and g0. Stimulus: hold op_ready=0 for 3 cycles after a bundle. Required: outputs stable, instr_ready=0, and the next instr is accepted the cycle op_ready rises. Separately, an instruction with rs1=0 and rf_data_a=0xDEAD must give op_a=0.
5. Flush. Stimulus: assert flush during EXTRA of an ST i=0. Required: no op_valid appears and state is FETCH, and the next instruction is accepted the cycle after flush deasserts.
6. Async reset. Stimulus: assert reset between clock edges while op_valid=1. Required: op_valid and all op_* outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer: drives the two register-file read ports, builds operand 2,
// and inserts a second read cycle for stores that need more than two register reads.
module operand_fetch_sequencer #(
  parameter int DATA_W  = 32,
  parameter bit ZERO_G0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic              flush,
  output logic [4:0]        rf_addr_a,
  output logic [4:0]        rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [31:0]       op_instr,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_st_lo,
  output logic [DATA_W-1:0] op_st_hi
);

  typedef enum logic {FETCH, EXTRA} state_t;

  function automatic logic is_store(input logic [31:0] w);
    return (w[31:30] == 2'b11) && (w[24:23] == 2'b00) && w[21];
  endfunction

  function automatic logic is_std(input logic [31:0] w);
    return is_store(w) && (w[24:19] == 6'h07);
  endfunction

  function automatic logic signed [DATA_W-1:0] sext13(input logic signed [12:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] port_data(input logic [4:0] addr,
                                                  input logic [DATA_W-1:0] data);
    return (ZERO_G0 && addr == 5'd0) ? '0 : data;
  endfunction

  state_t            state;
  logic [31:0]       hold_instr_p0;
  logic [DATA_W-1:0] hold_a_p0;
  logic [DATA_W-1:0] hold_b_p0;

  logic [4:0]        rs1, rs2, rd, hold_rd;
  logic              store, two_cycle, hold_std, accept;
  logic [DATA_W-1:0] da, db, op2;

  assign rs1       = instr[18:14];
  assign rs2       = instr[4:0];
  assign rd        = instr[29:25];
  assign hold_rd   = hold_instr_p0[29:25];
  assign hold_std  = is_std(hold_instr_p0);
  assign store     = is_store(instr);
  assign two_cycle = is_std(instr) || (store && !instr[13]);

  // EXTRA re-aims both ports at the store data pair of the held instruction
  always_comb begin
    rf_addr_a = rs1;
    rf_addr_b = (store && !two_cycle) ? rd : rs2;
    if (state == EXTRA) begin
      rf_addr_a = hold_rd;
      rf_addr_b = hold_rd | 5'd1;
    end
  end

  assign da = port_data(rf_addr_a, rf_data_a);
  assign db = port_data(rf_addr_b, rf_data_b);

  always_comb begin
    case (instr[31:30])
      2'b00:   op2 = {instr[21:0], 10'b0};
      2'b01:   op2 = {instr[29:0], 2'b00};
      default: op2 = instr[13] ? sext13(instr[12:0]) : db;
    endcase
  end

  assign instr_ready = (state == FETCH) && !flush && (!op_valid || op_ready);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      op_valid      <= 1'b0;
      op_instr      <= '0;
      op_a          <= '0;
      op_b          <= '0;
      op_st_lo      <= '0;
      op_st_hi      <= '0;
      hold_instr_p0 <= '0;
      hold_a_p0     <= '0;
      hold_b_p0     <= '0;
    end else if (flush) begin
      state    <= FETCH;
      op_valid <= 1'b0;
    end else if (state == EXTRA) begin
      // second read cycle: bundle completes from the held operands plus store data
      op_instr <= hold_instr_p0;
      op_a     <= hold_a_p0;
      op_b     <= hold_b_p0;
      op_st_lo <= da;
      op_st_hi <= hold_std ? db : '0;
      op_valid <= 1'b1;
      state    <= FETCH;
    end else if (accept) begin
      if (two_cycle) begin
        hold_instr_p0 <= instr;
        hold_a_p0     <= da;
        hold_b_p0     <= op2;
        op_valid      <= 1'b0;
        state         <= EXTRA;
      end else begin
        op_instr <= instr;
        op_a     <= da;
        op_b     <= op2;
        op_st_lo <= store ? db : '0;
        op_st_hi <= '0;
        op_valid <= 1'b1;
      end
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule
